// File: rtl/servant_arbiter_if.sv
// rtl/servant_arbiter_if.sv - two-master / one-slave RAM port bundle for servant_arbiter
// master: arbiter side (takes requests, drives the shared slave); slave: environment side.
interface servant_arbiter_if #(
    parameter int AW = 11
);
    logic [AW-1:0] i_m0_adr;
    logic [31:0]   i_m0_dat;
    logic [3:0]    i_m0_sel;
    logic          i_m0_we;
    logic          i_m0_cyc;
    logic [31:0]   o_m0_rdt;
    logic          o_m0_ack;
    logic          o_m0_err;

    logic [AW-1:0] i_m1_adr;
    logic [31:0]   i_m1_dat;
    logic [3:0]    i_m1_sel;
    logic          i_m1_we;
    logic          i_m1_cyc;
    logic [31:0]   o_m1_rdt;
    logic          o_m1_ack;
    logic          o_m1_err;

    logic [AW-1:0] o_s_adr;
    logic [31:0]   o_s_dat;
    logic [3:0]    o_s_sel;
    logic          o_s_we;
    logic          o_s_cyc;
    logic [31:0]   i_s_rdt;
    logic          i_s_ack;

    logic [1:0]    o_grant;

    modport master (
        input  i_m0_adr, i_m0_dat, i_m0_sel, i_m0_we, i_m0_cyc,
        input  i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc,
        input  i_s_rdt, i_s_ack,
        output o_m0_rdt, o_m0_ack, o_m0_err,
        output o_m1_rdt, o_m1_ack, o_m1_err,
        output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
        output o_grant
    );

    modport slave (
        output i_m0_adr, i_m0_dat, i_m0_sel, i_m0_we, i_m0_cyc,
        output i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc,
        output i_s_rdt, i_s_ack,
        input  o_m0_rdt, o_m0_ack, o_m0_err,
        input  o_m1_rdt, o_m1_ack, o_m1_err,
        input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
        input  o_grant
    );
endinterface

// File: rtl/servant_arbiter.sv
// rtl/servant_arbiter.sv - round-robin arbiter of two masters onto one RAM port with ack timeout
// A grant holds until slave ack, master abort or timeout; every grant is followed by one IDLE cycle.
module servant_arbiter #(
    parameter int AW      = 11,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    servant_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS0 = 2'd1, BUS1 = 2'd2} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;

    logic        cur_cyc;
    logic        timeout_hit;
    logic        done_ack;
    logic        done_err;
    logic [AW-1:0] adr_mux;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // An abort (cyc low) suppresses both ack and err; an ack beats a coincident timeout.
    always_comb begin
        cur_cyc = 1'b0;
        if (state_q == BUS0) cur_cyc = bus.i_m0_cyc;
        if (state_q == BUS1) cur_cyc = bus.i_m1_cyc;
        timeout_hit = (cnt_q == TIMEOUT_CNT);
        done_ack    = cur_cyc && bus.i_s_ack;
        done_err    = cur_cyc && !bus.i_s_ack && timeout_hit;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_m0_cyc && (!bus.i_m1_cyc || last_q)) begin
                    state_d = BUS0;
                    grant_d = 2'b01;
                    last_d  = 1'b0;
                    cnt_d   = 16'd0;
                end else if (bus.i_m1_cyc) begin
                    state_d = BUS1;
                    grant_d = 2'b10;
                    last_d  = 1'b1;
                    cnt_d   = 16'd0;
                end
            end
            BUS0, BUS1: begin
                if (!cur_cyc || bus.i_s_ack || timeout_hit) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_comb begin
        adr_mux      = '0;
        bus.o_s_dat  = 32'd0;
        bus.o_s_sel  = 4'd0;
        bus.o_s_we   = 1'b0;
        bus.o_s_cyc  = 1'b0;
        bus.o_m0_rdt = 32'd0;
        bus.o_m0_ack = 1'b0;
        bus.o_m0_err = 1'b0;
        bus.o_m1_rdt = 32'd0;
        bus.o_m1_ack = 1'b0;
        bus.o_m1_err = 1'b0;
        case (state_q)
            BUS0: begin
                adr_mux      = bus.i_m0_adr;
                bus.o_s_dat  = bus.i_m0_dat;
                bus.o_s_sel  = bus.i_m0_sel;
                bus.o_s_we   = bus.i_m0_we;
                bus.o_s_cyc  = bus.i_m0_cyc && !timeout_hit;
                bus.o_m0_rdt = bus.i_s_rdt;
                bus.o_m0_ack = done_ack;
                bus.o_m0_err = done_err;
            end
            BUS1: begin
                adr_mux      = bus.i_m1_adr;
                bus.o_s_dat  = bus.i_m1_dat;
                bus.o_s_sel  = bus.i_m1_sel;
                bus.o_s_we   = bus.i_m1_we;
                bus.o_s_cyc  = bus.i_m1_cyc && !timeout_hit;
                bus.o_m1_rdt = bus.i_s_rdt;
                bus.o_m1_ack = done_ack;
                bus.o_m1_err = done_err;
            end
            default: ;
        endcase
    end

    assign bus.o_s_adr = adr_mux;
    assign bus.o_grant = grant_q;
endmodule
